// File: rtl/quad_paddle_tracker_pkg.sv
// quad_pkg: shared types and constants for the quadrature paddle tracker.
// Optional feature macro used elsewhere in this block: QUAD_GLITCH_FILTER_EN.
package quad_pkg;

    // Visible screen width; the paddle sprite must start inside it.
    localparam int SCREEN_W = 640;

    // Saturation value of the illegal-transition counter.
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // 2-bit decode result of one prev->current quadrature comparison.
    typedef enum logic [1:0] {
        QUAD_NONE    = 2'd0,
        QUAD_INC     = 2'd1,
        QUAD_DEC     = 2'd2,
        QUAD_ILLEGAL = 2'd3
    } quad_dec_t;

    // Post-reset priming sequence; decode is enabled only in PRIME_RUN.
    typedef enum logic [1:0] {
        PRIME_0   = 2'd0,
        PRIME_1   = 2'd1,
        PRIME_2   = 2'd2,
        PRIME_RUN = 2'd3
    } prime_state_t;

    // Classify a {A,B} transition. Gray order 00->01->11->10->00 counts up.
    function automatic quad_dec_t quad_decode(input logic [1:0] prev_ab,
                                              input logic [1:0] cur_ab);
        quad_dec_t res;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: res = QUAD_INC;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: res = QUAD_DEC;
            4'b0000, 4'b0101, 4'b1111, 4'b1010: res = QUAD_NONE;
            default:                            res = QUAD_ILLEGAL;
        endcase
        return res;
    endfunction

    // Clamp an 11-bit signed candidate position into [lo, hi].
    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                             input int lo,
                                             input int hi);
        logic [9:0] res;
        if (v < $signed(11'(lo)))
            res = 10'(lo);
        else if (v > $signed(11'(hi)))
            res = 10'(hi);
        else
            res = v[9:0];
        return res;
    endfunction

endpackage

// File: rtl/quad_paddle_tracker_if.sv
// Bundle of the tracker's encoder, sync and paddle signals.
// Timing contract: there is no valid/ready handshake. quadA/quadB may change at
// any time (asynchronous); vga_v_sync is sampled on every clk rising edge; all
// outputs are registered, change only after a clk rising edge, and frame_strobe
// is high for exactly the one cycle in which pos_frame takes a new value.
interface quad_paddle_tracker_if;
    import quad_pkg::*;

    logic         quadA;
    logic         quadB;
    logic         vga_v_sync;
    logic [9:0]   pos;
    logic [9:0]   pos_frame;
    logic         frame_strobe;
    logic         dir;
    logic [7:0]   err_cnt;
    prime_state_t dbg_prime;

    // Producer of encoder/sync inputs, consumer of paddle outputs.
    modport master (
        output quadA, quadB, vga_v_sync,
        input  pos, pos_frame, frame_strobe, dir, err_cnt, dbg_prime
    );

    // The tracker itself.
    modport slave (
        input  quadA, quadB, vga_v_sync,
        output pos, pos_frame, frame_strobe, dir, err_cnt, dbg_prime
    );
endinterface

// File: rtl/quad_paddle_tracker_sync_filter.sv
// quad_sync_filter: 2-FF synchronizer for one quadrature phase, followed by an
// optional glitch filter enabled with QUAD_GLITCH_FILTER_EN. Without the macro
// the synchronizer output is passed straight through.
module quad_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be in 2..15");
    end

    logic [1:0] r_sync;

    // Two-stage synchronizer; r_sync[1] is the first metastability-safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sync <= 2'b00;
        else
            r_sync <= {r_sync[0], i_async};
    end

`ifdef QUAD_GLITCH_FILTER_EN
    logic       r_cand;
    logic       r_filt;
    logic [3:0] r_cnt;

    // Accept a new level only after FILTER_LEN identical consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (r_sync[1] != r_cand) begin
            r_cand <= r_sync[1];
            r_cnt  <= 4'd1;
        end else if (r_cnt != 4'(FILTER_LEN)) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(FILTER_LEN - 1))
                r_filt <= r_cand;
        end
    end

    assign o_sync = r_filt;
`else
    assign o_sync = r_sync[1];
`endif

endmodule

// File: rtl/quad_paddle_tracker.sv
// quad_paddle_tracker: decodes quadrature encoder phases into a clamped paddle X
// position, latches a frame-stable copy on vga_v_sync rising edges, and counts
// illegal transitions. Optional glitch filter: QUAD_GLITCH_FILTER_EN.
module quad_paddle_tracker
    import quad_pkg::*;
#(
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 576,
    parameter int POS_INIT   = 100,
    parameter int STEP       = 1,
    parameter int FILTER_LEN = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    quad_paddle_tracker_if.slave  bus
);

    if (STEP < 1 || STEP > 15) begin : g_bad_step
        $error("STEP must be in 1..15");
    end
    if (POS_MIN < 0 || POS_MAX > SCREEN_W - 1 || POS_MIN > POS_MAX) begin : g_bad_range
        $error("POS_MIN/POS_MAX must satisfy 0 <= POS_MIN <= POS_MAX < SCREEN_W");
    end

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [1:0]          w_s;
    logic [1:0]          r_prev;
    prime_state_t        r_prime;
    logic                w_decode_en;
    quad_dec_t           w_dec;
    logic signed [10:0]  w_up_raw;
    logic signed [10:0]  w_dn_raw;
    logic [9:0]          w_pos_up;
    logic [9:0]          w_pos_dn;
    logic [9:0]          r_pos;
    logic                r_dir;
    logic [7:0]          r_err;
    logic                r_vs_d;
    logic                w_vs_rise;
    logic [9:0]          r_pos_frame;
    logic                r_strobe;

    // Reset assert is immediate; release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_async(bus.quadA),
        .o_sync (w_s[1])
    );

    quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_async(bus.quadB),
        .o_sync (w_s[0])
    );

    // Priming FSM: hold decode off for three cycles while synchronizers fill.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prime <= PRIME_0;
        end else begin
            case (r_prime)
                PRIME_0: r_prime <= PRIME_1;
                PRIME_1: r_prime <= PRIME_2;
                PRIME_2: r_prime <= PRIME_RUN;
                default: r_prime <= PRIME_RUN;
            endcase
        end
    end
    assign w_decode_en = (r_prime == PRIME_RUN);

    // Previous synchronized phase pair, tracked even while priming.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_prev <= 2'b00;
        else
            r_prev <= w_s;
    end

    assign w_dec = quad_decode(r_prev, w_s);

    // Candidate positions in signed 11-bit so underflow below zero is visible.
    always_comb begin
        w_up_raw = $signed({1'b0, r_pos}) + $signed(11'(STEP));
        w_dn_raw = $signed({1'b0, r_pos}) - $signed(11'(STEP));
        w_pos_up = clamp_pos(w_up_raw, POS_MIN, POS_MAX);
        w_pos_dn = clamp_pos(w_dn_raw, POS_MIN, POS_MAX);
    end

    // Apply the decoded move: position, direction and saturating error count.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pos <= 10'(POS_INIT);
            r_dir <= 1'b0;
            r_err <= 8'd0;
        end else if (w_decode_en) begin
            case (w_dec)
                QUAD_INC: begin
                    r_pos <= w_pos_up;
                    r_dir <= 1'b1;
                end
                QUAD_DEC: begin
                    r_pos <= w_pos_dn;
                    r_dir <= 1'b0;
                end
                QUAD_ILLEGAL: begin
                    if (r_err != ERR_CNT_MAX)
                        r_err <= r_err + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_vs_rise = bus.vga_v_sync & ~r_vs_d;

    // Frame latch: capture the registered position on each vsync rising edge.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vs_d      <= 1'b0;
            r_pos_frame <= 10'(POS_INIT);
            r_strobe    <= 1'b0;
        end else begin
            r_vs_d   <= bus.vga_v_sync;
            r_strobe <= w_vs_rise;
            if (w_vs_rise)
                r_pos_frame <= r_pos;
        end
    end

    assign bus.pos          = r_pos;
    assign bus.pos_frame    = r_pos_frame;
    assign bus.frame_strobe = r_strobe;
    assign bus.dir          = r_dir;
    assign bus.err_cnt      = r_err;
    assign bus.dbg_prime    = r_prime;

endmodule
